// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble), one input bit per clock.
// Results are published only when a conversion completes, so a display reading bcd/lz never sees partial digits.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk100mhz,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     lz
);

  // state   | meaning
  // S_IDLE  | waiting for start; bcd/lz hold last result
  // S_SHIFT | one add-3 + shift per clock, WIDTH clocks total
  // S_DONE  | publish acc to bcd/lz, pulse done

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] LZ_RST = ~DIGITS'(1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t              state;
  logic [WIDTH-1:0]    sh;
  logic [4*DIGITS-1:0] acc;
  logic [4*DIGITS-1:0] acc_adj;
  logic [CW-1:0]       cnt;
  logic [DIGITS-1:0]   lz_next;
  logic                higher_zero;

  // Add-3 per digit, no carry between digits.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    lz_next     = '0;
    higher_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      higher_zero = higher_zero & (acc[4*i +: 4] == 4'd0);
      lz_next[i]  = higher_zero;
    end
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk100mhz or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      sh    <= '0;
      acc   <= '0;
      cnt   <= '0;
      bcd   <= '0;
      lz    <= LZ_RST;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            sh    <= bin;
            acc   <= '0;
            cnt   <= '0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {acc, sh} <= {acc_adj[4*DIGITS-2:0], sh, 1'b0};
          cnt       <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1))
            state <= S_DONE;
        end
        S_DONE: begin
          bcd   <= acc;
          lz    <= lz_next;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: constant vector table, multi-cycle corner sequences,
// and random values checked against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;
  logic        clk100mhz = 1'b0;
  logic        reset_n   = 1'b1;
  logic        start     = 1'b0;
  logic [15:0] bin       = '0;
  logic        busy, done;
  logic [19:0] bcd;
  logic [4:0]  lz;

  int tests  = 0;
  int failed = 0;

  always #5 clk100mhz = ~clk100mhz;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk100mhz(clk100mhz),
    .reset_n  (reset_n),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .lz       (lz)
  );

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
    logic [4:0]  lz;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: decimal digits by repeated division; digit i is a leading zero iff value < 10^i.
  function automatic void model(input int v, output logic [19:0] b, output logic [4:0] z);
    int t;
    t = v;
    b = '0;
    for (int i = 0; i < 5; i++) begin
      b[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    z = '0;
    for (int i = 1; i < 5; i++)
      if (v < 10 ** i) z[i] = 1'b1;
  endfunction

  task automatic conv(input logic [15:0] v, input logic [19:0] eb, input logic [4:0] ez);
    int k, nbusy;
    @(negedge clk100mhz);
    bin   = v;
    start = 1'b1;
    @(posedge clk100mhz);
    @(negedge clk100mhz);
    start = 1'b0;
    bin   = ~v;
    k     = 0;
    nbusy = 0;
    while (!done && k < 40) begin
      if (busy) nbusy++;
      @(negedge clk100mhz);
      k++;
    end
    chk("latency", 32'(k), 32'd17);
    chk("busy_cycles", 32'(nbusy), 32'd17);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("bcd", 32'(bcd), 32'(eb));
    chk("lz", 32'(lz), 32'(ez));
    @(negedge clk100mhz);
    chk("done_width", 32'(done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [19:0] eb, prev;
    logic [4:0]  ez;
    int k, ndone, held_bad;
    int dpos [3];
    logic [19:0] dval [3];

    tbl[0] = '{16'd0,     20'h00000, 5'b11110};
    tbl[1] = '{16'd65535, 20'h65535, 5'b00000};
    tbl[2] = '{16'd1234,  20'h01234, 5'b10000};
    tbl[3] = '{16'd9,     20'h00009, 5'b11110};
    tbl[4] = '{16'd10,    20'h00010, 5'b11100};
    tbl[5] = '{16'd100,   20'h00100, 5'b11000};
    tbl[6] = '{16'd9999,  20'h09999, 5'b10000};
    tbl[7] = '{16'd10000, 20'h10000, 5'b00000};

    #1 reset_n = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_lz", 32'(lz), 32'b11110);
    @(negedge clk100mhz);
    @(negedge clk100mhz);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++)
      conv(tbl[i].bin, tbl[i].bcd, tbl[i].lz);

    // Start pulses at E5 and at the DONE edge must be ignored.
    prev = tbl[7].bcd;
    @(negedge clk100mhz);
    bin = 16'd100;
    start = 1'b1;
    @(posedge clk100mhz);
    @(negedge clk100mhz);
    start = 1'b0;
    k = 0;
    held_bad = 0;
    while (!done && k < 40) begin
      if (bcd !== prev) held_bad++;
      if (k == 4 || k == 16) begin start = 1'b1; bin = 16'd7; end
      else start = 1'b0;
      @(negedge clk100mhz);
      k++;
    end
    start = 1'b0;
    chk("ign_latency", 32'(k), 32'd17);
    chk("ign_bcd_held", 32'(held_bad), 32'd0);
    chk("ign_bcd", 32'(bcd), 32'h00100);
    ndone = 0;
    repeat (25) begin
      @(negedge clk100mhz);
      if (done || busy) ndone++;
    end
    chk("ign_no_extra", 32'(ndone), 32'd0);

    // Start held high: back-to-back conversions re-sample bin at each accept edge.
    @(negedge clk100mhz);
    bin = 16'd10;
    start = 1'b1;
    @(posedge clk100mhz);
    ndone = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk100mhz);
      if (done) begin
        if (ndone < 3) begin dpos[ndone] = n; dval[ndone] = bcd; end
        ndone++;
      end
      if (n == 0)  bin = 16'd20;
      if (n == 18) bin = 16'd30;
      if (n == 36) start = 1'b0;
    end
    chk("b2b_count", 32'(ndone), 32'd3);
    if (ndone >= 3) begin
      chk("b2b_pos0", 32'(dpos[0]), 32'd17);
      chk("b2b_pos1", 32'(dpos[1]), 32'd35);
      chk("b2b_pos2", 32'(dpos[2]), 32'd53);
      chk("b2b_val0", 32'(dval[0]), 32'h00010);
      chk("b2b_val1", 32'(dval[1]), 32'h00020);
      chk("b2b_val2", 32'(dval[2]), 32'h00030);
    end

    // Reset between E7 and E8 aborts a running conversion.
    conv(16'd4321, 20'h04321, 5'b10000);
    @(negedge clk100mhz);
    bin = 16'd999;
    start = 1'b1;
    @(posedge clk100mhz);
    @(negedge clk100mhz);
    start = 1'b0;
    repeat (7) @(negedge clk100mhz);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_bcd", 32'(bcd), 32'd0);
    chk("abort_lz", 32'(lz), 32'b11110);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk100mhz);
    reset_n = 1'b1;
    ndone = 0;
    repeat (25) begin
      @(negedge clk100mhz);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    conv(16'd42, 20'h00042, 5'b11100);

    for (int i = 0; i < 1500; i++) begin
      logic [15:0] v;
      v = 16'($urandom_range(0, 65535));
      model(int'(v), eb, ez);
      conv(v, eb, ez);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
